options_header_collector: RTL and testbench

- Upstream feeder for the options parser stage.
- Assembles one IPv4 header, 5..15 32-bit words, from a word-serial input stream into a 15-slot field array, zero-filling unused slots.
- Presents the array to the parser with the standard sig/sync/notify handshake.
- Drops malformed headers and counts them.

---
 rtl/options_header_collector.sv | 225 ++++++++++++++++++++++
 tb/tb_options_header_collector.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/options_header_collector.sv
// ---------------------------------------------------------------------------
// options_header_collector
//
// Purpose:
//   Upstream feeder for the options parser stage. Collects one IPv4 header
//   (IHL = 5..15 words) from a word-serial stream into a fixed array of
//   MAX_WORDS slots. Slots past the header length are zero-filled. The array
//   is offered with a sig/sync/notify handshake. Malformed headers (IHL too
//   small, IHL > MAX_WORDS, or aborted by a new sop) are dropped and counted.
//
// Optional build macro:
//   OPTIONS_HDR_CHECKSUM_EN - adds a ones-complement header checksum check
//                             and the ckErr output.
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   asynchronous active-low reset
//   wordIn_sig       in   header word
//   wordIn_sop       in   first word of a header (qualified by wordIn_sync)
//   wordIn_sync      in   producer has a valid word
//   wordIn_notify    out  block accepts a word this cycle
//   fieldsOut_sig    out  field array, slot i at [i*WORD_W +: WORD_W]
//   fieldsOut_notify out  array valid and offered
//   fieldsOut_sync   in   consumer takes the array
//   errCount         out  saturating count of dropped headers
//   ckErr            out  one-cycle pulse per checksum drop (macro only)
// ---------------------------------------------------------------------------
module options_header_collector #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned MAX_WORDS = 15,
    parameter int unsigned MIN_IHL   = 5,
    parameter int unsigned ERR_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WORD_W-1:0]           wordIn_sig,
    input  logic                        wordIn_sop,
    input  logic                        wordIn_sync,
    output logic                        wordIn_notify,
    output logic [MAX_WORDS*WORD_W-1:0] fieldsOut_sig,
    output logic                        fieldsOut_notify,
    input  logic                        fieldsOut_sync,
    output logic [ERR_W-1:0]            errCount
`ifdef OPTIONS_HDR_CHECKSUM_EN
    ,
    output logic                        ckErr
`endif
);

    // idx must be able to hold the value MAX_WORDS (reached on the last word)
    localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned IHL_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OFFER   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idxNext;
    logic [IHL_W-1:0]   ihl;
    logic [IHL_W-1:0]   ihlNext;
    logic [WORD_W-1:0]  slots [MAX_WORDS];

    logic               wordAccept;
    logic               xfer;
    logic [IHL_W-1:0]   sopIhl;
    logic               sopLegal;
    logic               doSop;
    logic               doWord;
    logic               lastWord;
    logic               errHit;
    logic               ckDrop;

    assign wordAccept = wordIn_sync & wordIn_notify;
    assign xfer       = fieldsOut_notify & fieldsOut_sync;
    assign sopIhl     = wordIn_sig[27:24];
    assign sopLegal   = (32'(sopIhl) >= MIN_IHL) && (32'(sopIhl) <= MAX_WORDS);
    assign lastWord   = (32'(idx) + 32'd1) == 32'(ihl);

`ifdef OPTIONS_HDR_CHECKSUM_EN
    logic [15:0] ckAcc;
    logic [15:0] ckBase;
    logic [15:0] ckSum;

    // ones-complement add with the end-around carry folded back in
    function automatic logic [15:0] onesAdd(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + 16'(s[16]);
    endfunction

    // a sop restarts the sum from zero in the same cycle it is stored
    assign ckBase = doSop ? 16'h0000 : ckAcc;
    assign ckSum  = onesAdd(onesAdd(ckBase, wordIn_sig[31:16]), wordIn_sig[15:0]);
`endif

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // next state and datapath controls
    always_comb begin
        stateNext = state;
        idxNext   = idx;
        ihlNext   = ihl;
        doSop     = 1'b0;
        doWord    = 1'b0;
        errHit    = 1'b0;
        ckDrop    = 1'b0;

        unique case (state)
            IDLE, DISCARD: begin
                doSop = wordAccept & wordIn_sop;
            end
            COLLECT: begin
                doSop  = wordAccept & wordIn_sop;
                doWord = wordAccept & ~wordIn_sop;
                // a new sop aborts the header in progress
                errHit = doSop;
            end
            OFFER: begin
                if (xfer) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (doSop) begin
            if (sopLegal) begin
                stateNext = COLLECT;
                idxNext   = IDX_W'(1);
                ihlNext   = sopIhl;
            end else begin
                errHit    = 1'b1;
                stateNext = DISCARD;
            end
        end

        if (doWord) begin
            idxNext = idx + IDX_W'(1);
            if (lastWord) begin
`ifdef OPTIONS_HDR_CHECKSUM_EN
                if (ckSum == 16'hFFFF) begin
                    stateNext = OFFER;
                end else begin
                    errHit    = 1'b1;
                    ckDrop    = 1'b1;
                    stateNext = IDLE;
                end
`else
                stateNext = OFFER;
`endif
            end
        end
    end

    // registered handshakes, indices and error counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx              <= '0;
            ihl              <= '0;
            wordIn_notify    <= 1'b0;
            fieldsOut_notify <= 1'b0;
            errCount         <= '0;
        end else begin
            idx              <= idxNext;
            ihl              <= ihlNext;
            wordIn_notify    <= (stateNext != OFFER);
            fieldsOut_notify <= (stateNext == OFFER);
            if (errHit && (errCount != {ERR_W{1'b1}})) begin
                errCount <= errCount + ERR_W'(1);
            end
        end
    end

    // field slots: a legal sop stores slot 0 and zero-fills the rest
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MAX_WORDS; i++) begin
                slots[i] <= '0;
            end
        end else if (doSop && sopLegal) begin
            slots[0] <= wordIn_sig;
            for (int unsigned i = 1; i < MAX_WORDS; i++) begin
                slots[i] <= '0;
            end
        end else if (doWord) begin
            slots[idx] <= wordIn_sig;
        end
    end

`ifdef OPTIONS_HDR_CHECKSUM_EN
    // checksum accumulator and drop pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ckAcc <= '0;
            ckErr <= 1'b0;
        end else begin
            ckErr <= ckDrop;
            if ((doSop && sopLegal) || doWord) begin
                ckAcc <= ckSum;
            end
        end
    end
`endif

    // flatten slots onto the output bus
    for (genvar g = 0; g < MAX_WORDS; g++) begin : g_pack
        assign fieldsOut_sig[g*WORD_W +: WORD_W] = slots[g];
    end

endmodule

// File: tb/tb_options_header_collector.sv
module tb_options_header_collector;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned MAX_WORDS = 15;
    localparam int unsigned MIN_IHL   = 5;
    localparam int unsigned ERR_W     = 16;
    localparam int unsigned ARR_W     = MAX_WORDS * WORD_W;

    typedef logic [31:0] wq_t[$];

    logic                clk;
    logic                rst;
    logic [WORD_W-1:0]   wordIn_sig;
    logic                wordIn_sop;
    logic                wordIn_sync;
    logic                wordIn_notify;
    logic [ARR_W-1:0]    fieldsOut_sig;
    logic                fieldsOut_notify;
    logic                fieldsOut_sync;
    logic [ERR_W-1:0]    errCount;
`ifdef OPTIONS_HDR_CHECKSUM_EN
    logic                ckErr;
`endif

    options_header_collector #(
        .WORD_W    (WORD_W),
        .MAX_WORDS (MAX_WORDS),
        .MIN_IHL   (MIN_IHL),
        .ERR_W     (ERR_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wordIn_sig       (wordIn_sig),
        .wordIn_sop       (wordIn_sop),
        .wordIn_sync      (wordIn_sync),
        .wordIn_notify    (wordIn_notify),
        .fieldsOut_sig    (fieldsOut_sig),
        .fieldsOut_notify (fieldsOut_notify),
        .fieldsOut_sync   (fieldsOut_sync),
        .errCount         (errCount)
`ifdef OPTIONS_HDR_CHECKSUM_EN
        ,
        .ckErr            (ckErr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nChecks  = 0;
    int          nFail    = 0;
    int unsigned modelErr = 0;
    bit          pending  = 1'b0;
    bit          randGaps = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkB(input string tag, input logic obs, input logic exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkArr(input string tag, input logic [ARR_W-1:0] obs, input logic [ARR_W-1:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // expected array: first n words of the header, remaining slots zero
    function automatic logic [ARR_W-1:0] expArray(input wq_t w, input int n);
        logic [ARR_W-1:0] a;
        a = '0;
        for (int i = 0; i < n; i++) a[i*WORD_W +: WORD_W] = w[i];
        return a;
    endfunction

`ifdef OPTIONS_HDR_CHECKSUM_EN
    // ones-complement sum of all 16-bit halves, folded with plain integer arithmetic
    function automatic longint unsigned foldSum(input wq_t w, input int n);
        longint unsigned t;
        t = 0;
        for (int i = 0; i < n; i++) t += 64'(w[i][31:16]) + 64'(w[i][15:0]);
        while (t > 64'hFFFF) t = (t & 64'hFFFF) + (t >> 16);
        return t;
    endfunction

    function automatic bit ckOk(input wq_t w, input int n);
        return foldSum(w, n) == 64'hFFFF;
    endfunction
`endif

    // place a correct IPv4 checksum in word 2 when the checksum build is used
    function automatic wq_t prep(input wq_t w);
        wq_t r;
        r = w;
`ifdef OPTIONS_HDR_CHECKSUM_EN
        begin
            longint unsigned t;
            r[2][15:0] = 16'h0000;
            t = foldSum(r, 32'(r[0][27:24]));
            r[2][15:0] = ~16'(t);
        end
`endif
        return r;
    endfunction

    // drive one word until accepted (bounded wait)
    task automatic pushWord(input logic [31:0] w, input logic s);
        int guard;
        guard = 0;
        if (randGaps && ($urandom_range(0, 3) == 0)) begin
            wordIn_sync = 1'b0;
            tick();
        end
        wordIn_sig  = w;
        wordIn_sop  = s;
        wordIn_sync = 1'b1;
        while ((wordIn_notify !== 1'b1) && (guard < 50)) begin
            tick();
            guard++;
        end
        if (guard >= 50) chkB("acceptTimeout", wordIn_notify, 1'b1);
        tick();
        wordIn_sync = 1'b0;
        wordIn_sop  = 1'b0;
    endtask

    // hold the offer for bp cycles, then take it
    task automatic takeOffer(input logic [ARR_W-1:0] exp, input int bp);
        chkArr("offerSig", fieldsOut_sig, exp);
        chkB("offerInStall", wordIn_notify, 1'b0);
        // an illegal sop offered during the stall must not be taken
        wordIn_sig  = 32'h4000_0000 | ($urandom & 32'h00FF_FFFF);
        wordIn_sig[27:24] = 4'd0;
        wordIn_sop  = 1'b1;
        wordIn_sync = 1'b1;
        for (int c = 0; c < bp; c++) begin
            tick();
            chkB("bpInNotify", wordIn_notify, 1'b0);
            chkB("bpOutNotify", fieldsOut_notify, 1'b1);
            chkArr("bpHold", fieldsOut_sig, exp);
        end
        wordIn_sync    = 1'b0;
        wordIn_sop     = 1'b0;
        fieldsOut_sync = 1'b1;
        tick();
        fieldsOut_sync = 1'b0;
        chkB("xferNotifyDrop", fieldsOut_notify, 1'b0);
        chkB("xferInReady", wordIn_notify, 1'b1);
        chkArr("xferRetain", fieldsOut_sig, exp);
        chk16("xferErr", errCount, 16'(modelErr));
    endtask

    // one segment: sop word plus nSend-1 following words
    task automatic runSeg(input wq_t w, input int nSend, input int bp);
        int ihl;
        int upto;
        bit legal;
        bit good;
        ihl   = 32'(w[0][27:24]);
        legal = (ihl >= MIN_IHL) && (ihl <= MAX_WORDS);
        if (pending || !legal) modelErr++;
        pending = 1'b0;
        pushWord(w[0], 1'b1);
        chk16("errAfterSop", errCount, 16'(modelErr));
        if (!legal) begin
            for (int i = 1; i < nSend; i++) pushWord(w[i], 1'b0);
            chkB("illegalNoOffer", fieldsOut_notify, 1'b0);
            chk16("illegalErr", errCount, 16'(modelErr));
            return;
        end
        upto = (nSend < ihl) ? nSend : ihl;
        for (int i = 1; i < upto; i++) begin
            pushWord(w[i], 1'b0);
            if (i < ihl - 1) chkB("earlyNotify", fieldsOut_notify, 1'b0);
        end
        if (nSend < ihl) begin
            pending = 1'b1;
            return;
        end
        good = 1'b1;
`ifdef OPTIONS_HDR_CHECKSUM_EN
        good = ckOk(w, ihl);
`endif
        if (!good) modelErr++;
        chkB("notifyLatency", fieldsOut_notify, good);
        chk16("errAtEnd", errCount, 16'(modelErr));
`ifdef OPTIONS_HDR_CHECKSUM_EN
        chkB("ckErrPulse", ckErr, !good);
        if (!good) begin
            tick();
            chkB("ckErrClear", ckErr, 1'b0);
            chkB("ckNoOffer", fieldsOut_notify, 1'b0);
            chkB("ckInReady", wordIn_notify, 1'b1);
        end
`endif
        if (good) takeOffer(expArray(w, ihl), bp);
        for (int i = ihl; i < nSend; i++) pushWord(w[i], 1'b0);
        if (nSend > ihl) begin
            chkB("trailNoOffer", fieldsOut_notify, 1'b0);
            chk16("trailErr", errCount, 16'(modelErr));
        end
    endtask

    // global time bound
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        wq_t w;
        wq_t bad;
        int  ihl;
        int  nSend;

        rst            = 1'b1;
        wordIn_sig     = '0;
        wordIn_sop     = 1'b0;
        wordIn_sync    = 1'b0;
        fieldsOut_sync = 1'b0;
        #2 rst = 1'b0;
        tick();
        tick();
        chkB("rstInNotify", wordIn_notify, 1'b0);
        chkB("rstOutNotify", fieldsOut_notify, 1'b0);
        chkArr("rstSig", fieldsOut_sig, '0);
        chk16("rstErr", errCount, 16'd0);
        rst = 1'b1;
        #1;
        chkB("relInNotifyLow", wordIn_notify, 1'b0);
        tick();
        chkB("relInNotifyHigh", wordIn_notify, 1'b1);

        // IHL=5 header
        w = {32'h4500_0054, $urandom, $urandom, $urandom, $urandom};
        runSeg(prep(w), 5, 0);

        // IHL=15 header, words 1..14
        w = {32'h4F00_0000};
        for (int i = 1; i < 15; i++) w.push_back(32'(i));
        runSeg(prep(w), 15, 0);

        // illegal IHL then a legal header
        w = {32'h4300_0000, $urandom, $urandom};
        runSeg(w, 3, 0);
        w = {32'h4500_0000 | ($urandom & 32'h0000_FFFF), $urandom, $urandom, $urandom, $urandom};
        runSeg(prep(w), 5, 0);

        // sop mid-collection aborts the first header
        w = {32'h4600_0000, $urandom, $urandom};
        runSeg(w, 3, 0);
        w = {32'h4500_0000, $urandom, $urandom, $urandom, $urandom};
        runSeg(prep(w), 5, 0);

        // output backpressure for 10 cycles
        w = {32'h4700_1234, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        runSeg(prep(w), 7, 10);

        // async reset mid-collection
        pushWord(32'h4600_0000, 1'b1);
        pushWord($urandom, 1'b0);
        pushWord($urandom, 1'b0);
        rst = 1'b0;
        #1;
        chkB("midRstInNotify", wordIn_notify, 1'b0);
        chkB("midRstOutNotify", fieldsOut_notify, 1'b0);
        chkArr("midRstSig", fieldsOut_sig, '0);
        chk16("midRstErr", errCount, 16'd0);
`ifdef OPTIONS_HDR_CHECKSUM_EN
        chkB("midRstCkErr", ckErr, 1'b0);
`endif
        modelErr = 0;
        pending  = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chkB("postRstReady", wordIn_notify, 1'b1);
        chkB("postRstNoOffer", fieldsOut_notify, 1'b0);
        w = prep({32'h4500_0000 | ($urandom & 32'h00FF_FFFF), $urandom, $urandom, $urandom, $urandom});
        w[0][27:24] = 4'd5;
        w = prep(w);
        runSeg(w, 5, 0);
        bad = w;
        bad[3] = bad[3] ^ 32'h0000_0100;
        runSeg(bad, 5, 0);

        // randomized segments
        randGaps = 1'b1;
        for (int n = 0; n < 60; n++) begin
            w = {};
            if ($urandom_range(0, 4) == 0) begin
                ihl = $urandom_range(0, MIN_IHL - 1);
                nSend = $urandom_range(1, 3);
                for (int i = 0; i < nSend; i++) w.push_back($urandom);
                w[0][27:24] = 4'(ihl);
            end else begin
                ihl = $urandom_range(MIN_IHL, MAX_WORDS);
                for (int i = 0; i < ihl; i++) w.push_back($urandom);
                w[0][27:24] = 4'(ihl);
                w = prep(w);
                if ($urandom_range(0, 3) == 0) begin
                    int k;
                    k = $urandom_range(1, ihl - 1);
                    w[k] = w[k] ^ (32'd1 << $urandom_range(0, 31));
                end
                if ($urandom_range(0, 6) == 0) begin
                    nSend = $urandom_range(1, ihl - 1);
                end else begin
                    nSend = ihl + $urandom_range(0, 2);
                    for (int i = ihl; i < nSend; i++) w.push_back($urandom);
                end
            end
            runSeg(w, nSend, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
